// File: rtl/ofmap_piso.sv
// Parallel-in serial-out stage for the ofmap path: takes one OC0-lane vector and streams it lane 0 first.
// Optional ofmap_last output when OFMAP_PISO_LAST_EN is defined.
module ofmap_piso #(
    parameter int OC0      = 2,
    parameter int DATA_WID = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OC0*DATA_WID-1:0] par_dat,
    input  logic                    par_vld,
    output logic                    par_rdy,
    output logic [DATA_WID-1:0]     ofmap_dat,
    output logic                    ofmap_vld,
    input  logic                    ofmap_rdy,
`ifdef OFMAP_PISO_LAST_EN
    output logic                    ofmap_last,
`endif
    output logic                    busy
);
    localparam int IDX_WID = $clog2(OC0) + 1;
    localparam logic [IDX_WID-1:0] IDX_LAST = IDX_WID'(OC0 - 1);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t                  state, state_nxt;
    logic [IDX_WID-1:0]      idx, idx_nxt;
    logic [OC0*DATA_WID-1:0] hold;
    logic                    load;
    logic                    last;

    assign last = (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) hold <= par_dat;
        end
    end

    // A new vector may be taken on the same edge the last word leaves, so back-to-back vectors have no bubble.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        par_rdy   = 1'b0;
        ofmap_vld = 1'b0;
        case (state)
            IDLE: begin
                par_rdy = 1'b1;
                if (par_vld) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                ofmap_vld = 1'b1;
                par_rdy   = last && ofmap_rdy;
                if (ofmap_rdy) begin
                    if (!last) begin
                        idx_nxt = idx + IDX_WID'(1);
                    end else if (par_vld) begin
                        load    = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output word is a plain mux over the hold register, zero when nothing is held.
    always_comb begin
        ofmap_dat = '0;
        for (int k = 0; k < OC0; k++)
            if (ofmap_vld && idx == IDX_WID'(k))
                ofmap_dat = hold[k*DATA_WID +: DATA_WID];
    end

    assign busy = ofmap_vld;

`ifdef OFMAP_PISO_LAST_EN
    assign ofmap_last = ofmap_vld && last;
`endif

endmodule

// File: tb/tb_ofmap_piso.sv
// Directed bench for ofmap_piso (OC0=2): cycle table plus async-reset and random-stall sequences.
module tb_ofmap_piso;
    localparam int OC0 = 2;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [OC0*DW-1:0] par_dat = '0;
    logic              par_vld = 1'b0;
    logic              par_rdy;
    logic [DW-1:0]     ofmap_dat;
    logic              ofmap_vld;
    logic              ofmap_rdy = 1'b1;
    logic              busy;
`ifdef OFMAP_PISO_LAST_EN
    logic              ofmap_last;
`endif

    ofmap_piso #(.OC0(OC0), .DATA_WID(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .par_dat   (par_dat),
        .par_vld   (par_vld),
        .par_rdy   (par_rdy),
        .ofmap_dat (ofmap_dat),
        .ofmap_vld (ofmap_vld),
        .ofmap_rdy (ofmap_rdy),
`ifdef OFMAP_PISO_LAST_EN
        .ofmap_last(ofmap_last),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst;
        logic              pv;
        logic [OC0*DW-1:0] pdat;
        logic              rdy;
        logic              e_prdy;
        logic              e_vld;
        logic [DW-1:0]     e_dat;
        logic              e_last;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic r, logic pv, logic [OC0*DW-1:0] pd, logic rd,
                                logic ep, logic ev, logic [DW-1:0] ed, logic el);
        vec_t v;
        v.rst = r; v.pv = pv; v.pdat = pd; v.rdy = rd;
        v.e_prdy = ep; v.e_vld = ev; v.e_dat = ed; v.e_last = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ep, input logic ev, input logic [DW-1:0] ed);
        chk({tag, ".par_rdy"}, DW'(par_rdy), DW'(ep));
        chk({tag, ".ofmap_vld"}, DW'(ofmap_vld), DW'(ev));
        chk({tag, ".ofmap_dat"}, ofmap_dat, ed);
        chk({tag, ".busy"}, DW'(busy), DW'(ev));
    endtask

    task automatic drive(input logic pv, input logic [OC0*DW-1:0] pd, input logic rd);
        @(negedge clk);
        par_vld = pv; par_dat = pd; ofmap_rdy = rd;
        #2;
    endtask

    localparam logic [OC0*DW-1:0] XD = 'x;

    initial begin
        logic          stalled;
        logic [DW-1:0] prev_dat;
        int            sent, got;

        // single vector
        tbl.push_back(mk(1, 0, XD, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, {32'h0000_0BBB, 32'h0000_0AAA}, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, XD, 1, 0, 1, 32'h0000_0AAA, 0));
        tbl.push_back(mk(0, 0, XD, 1, 1, 1, 32'h0000_0BBB, 1));
        tbl.push_back(mk(0, 0, XD, 1, 1, 0, 32'h0, 0));
        // back-to-back
        tbl.push_back(mk(0, 1, {32'd2, 32'd1}, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, {32'd4, 32'd3}, 1, 0, 1, 32'd1, 0));
        tbl.push_back(mk(0, 1, {32'd4, 32'd3}, 1, 1, 1, 32'd2, 1));
        tbl.push_back(mk(0, 1, {32'd6, 32'd5}, 1, 0, 1, 32'd3, 0));
        tbl.push_back(mk(0, 1, {32'd6, 32'd5}, 1, 1, 1, 32'd4, 1));
        tbl.push_back(mk(0, 0, XD, 1, 0, 1, 32'd5, 0));
        tbl.push_back(mk(0, 0, XD, 1, 1, 1, 32'd6, 1));
        tbl.push_back(mk(0, 0, XD, 1, 1, 0, 32'h0, 0));
        // backpressure on first word
        tbl.push_back(mk(0, 1, {32'h22, 32'h11}, 1, 1, 0, 32'h0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, XD, 0, 0, 1, 32'h11, 0));
        tbl.push_back(mk(0, 0, XD, 1, 0, 1, 32'h11, 0));
        tbl.push_back(mk(0, 0, XD, 1, 1, 1, 32'h22, 1));
        tbl.push_back(mk(0, 0, XD, 1, 1, 0, 32'h0, 0));
        // stall on last word, ignored par_vld while not ready
        tbl.push_back(mk(0, 1, {32'h8, 32'h7}, 1, 1, 0, 32'h0, 0));
        tbl.push_back(mk(0, 1, {32'hA, 32'h9}, 1, 0, 1, 32'h7, 0));
        tbl.push_back(mk(0, 1, {32'hA, 32'h9}, 0, 0, 1, 32'h8, 1));
        tbl.push_back(mk(0, 1, {32'hA, 32'h9}, 1, 1, 1, 32'h8, 1));
        tbl.push_back(mk(0, 1, {32'hDEAD, 32'hBEEF}, 1, 0, 1, 32'h9, 0));
        tbl.push_back(mk(0, 0, XD, 1, 1, 1, 32'hA, 1));
        tbl.push_back(mk(0, 0, XD, 1, 1, 0, 32'h0, 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; par_vld = tbl[i].pv; par_dat = tbl[i].pdat; ofmap_rdy = tbl[i].rdy;
            #2;
            chk($sformatf("row%0d", i), DW'(par_rdy), DW'(tbl[i].e_prdy));
            chk($sformatf("row%0d.vld", i), DW'(ofmap_vld), DW'(tbl[i].e_vld));
            chk($sformatf("row%0d.dat", i), ofmap_dat, tbl[i].e_dat);
            chk($sformatf("row%0d.busy", i), DW'(busy), DW'(tbl[i].e_vld));
`ifdef OFMAP_PISO_LAST_EN
            chk($sformatf("row%0d.last", i), DW'(ofmap_last), DW'(tbl[i].e_last));
`endif
        end

        // asynchronous reset between edges after the first word has gone
        drive(1, {32'h22, 32'h11}, 1);
        chk_outs("mid.load", 1, 0, 32'h0);
        drive(0, XD, 1);
        chk_outs("mid.w0", 0, 1, 32'h11);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_outs("mid.async", 1, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, {32'h44, 32'h33}, 1);
        chk_outs("mid.reload", 1, 0, 32'h0);
        drive(0, XD, 1);
        chk_outs("mid.w33", 0, 1, 32'h33);
        drive(0, XD, 1);
        chk_outs("mid.w44", 1, 1, 32'h44);
        drive(0, XD, 1);
        chk_outs("mid.idle", 1, 0, 32'h0);

        // random stalls on both sides, 9 vectors / 18 words
        sent = 0; got = 0; stalled = 1'b0; prev_dat = '0;
        for (int cyc = 0; cyc < 2000 && got < 18; cyc++) begin
            @(negedge clk);
            par_vld   = (sent < 9) && ($urandom_range(0, 1) == 1);
            par_dat   = {32'hC000_0000 + 32'(2*sent + 1), 32'hC000_0000 + 32'(2*sent)};
            ofmap_rdy = ($urandom_range(0, 1) == 1);
            #2;
            if (stalled) begin
                chk("rand.stall_vld", DW'(ofmap_vld), 32'd1);
                chk("rand.stall_dat", ofmap_dat, prev_dat);
            end
            if (par_vld && par_rdy) sent++;
            if (ofmap_vld && ofmap_rdy) begin
                chk("rand.word", ofmap_dat, 32'hC000_0000 + 32'(got));
                got++;
            end
            stalled  = ofmap_vld && !ofmap_rdy;
            prev_dat = ofmap_dat;
        end
        chk("rand.count", 32'(got), 32'd18);
        par_vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
